// File: rtl/msrv32_timer_pkg.sv
// Shared constants for the msrv32 machine timer unit.
// Word offsets of the register window and reset values.
package msrv32_timer_pkg;

    localparam logic [3:0] OFS_MTIME_LO    = 4'd0;
    localparam logic [3:0] OFS_MTIME_HI    = 4'd1;
    localparam logic [3:0] OFS_MTIMECMP_LO = 4'd2;
    localparam logic [3:0] OFS_MTIMECMP_HI = 4'd3;
    localparam logic [3:0] OFS_MSIP        = 4'd4;
    localparam logic [3:0] OFS_PRESC       = 4'd5;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MTIME_RST    = 64'h0;

endpackage

// File: rtl/msrv32_byte_mask_merge.sv
// Byte-lane merge of write data into a 32-bit register value.
// Bit n of the mask selects new data for byte n.
module msrv32_byte_mask_merge (
    input  logic [31:0] old_val,
    input  logic [31:0] new_val,
    input  logic [3:0]  mask_in,
    output logic [31:0] merged_out
);

    // Per-byte select between held and written data
    always_comb begin
        merged_out = old_val;
        for (int i = 0; i < 4; i++) begin
            if (mask_in[i]) begin
                merged_out[8*i +: 8] = new_val[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/msrv32_timer_unit.sv
// Memory-mapped machine timer and software interrupt unit.
// Provides mtime, mtimecmp, msip, prescaler and a registered read port.
module msrv32_timer_unit
    import msrv32_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          PRESC_W   = 8
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic [31:0] ms_riscv32_mp_dmaddr_in,
    input  logic [31:0] ms_riscv32_mp_dmdata_in,
    input  logic        ms_riscv32_mp_dmwr_req_in,
    input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
    output logic [31:0] tmr_rd_data_out,
    output logic        tmr_hit_out,
    output logic [63:0] ms_riscv32_mp_rc_out,
    output logic        ms_riscv32_mp_tirq_out,
    output logic        ms_riscv32_mp_sirq_out
);

    logic [63:0]        mtime_q, mtime_d;
    logic [63:0]        mtimecmp_q, mtimecmp_d;
    logic               msip_q, msip_d;
    logic [PRESC_W-1:0] prescale_q, prescale_d;
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [31:0]        hi_shadow_q, hi_shadow_d;
    logic [31:0]        rd_data_q, rd_data_d;
    logic               hit_q, hit_d;
    logic               tirq_q, tirq_d;

    logic        hit, wr, rd, tick;
    logic [3:0]  ofs;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] mtime_lo_m, mtime_hi_m;
    logic [31:0] cmp_lo_m, cmp_hi_m;
    logic [31:0] msip_m, presc_m, shadow_m;
    logic [31:0] presc_ext;
    logic        unused_bits;

    assign wdata     = ms_riscv32_mp_dmdata_in;
    assign wmask     = ms_riscv32_mp_dmwr_mask_in;
    assign ofs       = ms_riscv32_mp_dmaddr_in[5:2];
    assign hit       = ms_riscv32_mp_dmaddr_in[31:6] == BASE_ADDR[31:6];
    assign wr        = hit && ms_riscv32_mp_dmwr_req_in && (wmask != 4'b0000);
    assign rd        = hit && !ms_riscv32_mp_dmwr_req_in;
    assign tick      = presc_cnt_q == prescale_q;
    assign presc_ext = {{(32-PRESC_W){1'b0}}, prescale_q};

    msrv32_byte_mask_merge u_mtime_lo (
        .old_val(mtime_q[31:0]), .new_val(wdata),
        .mask_in(wmask), .merged_out(mtime_lo_m)
    );
    msrv32_byte_mask_merge u_mtime_hi (
        .old_val(mtime_q[63:32]), .new_val(wdata),
        .mask_in(wmask), .merged_out(mtime_hi_m)
    );
    msrv32_byte_mask_merge u_cmp_lo (
        .old_val(mtimecmp_q[31:0]), .new_val(wdata),
        .mask_in(wmask), .merged_out(cmp_lo_m)
    );
    msrv32_byte_mask_merge u_cmp_hi (
        .old_val(mtimecmp_q[63:32]), .new_val(wdata),
        .mask_in(wmask), .merged_out(cmp_hi_m)
    );
    msrv32_byte_mask_merge u_msip (
        .old_val({31'b0, msip_q}), .new_val(wdata),
        .mask_in(wmask), .merged_out(msip_m)
    );
    msrv32_byte_mask_merge u_presc (
        .old_val(presc_ext), .new_val(wdata),
        .mask_in(wmask), .merged_out(presc_m)
    );
    msrv32_byte_mask_merge u_shadow (
        .old_val(hi_shadow_q), .new_val(wdata),
        .mask_in(wmask), .merged_out(shadow_m)
    );

    assign unused_bits = ^{ms_riscv32_mp_dmaddr_in[1:0],
                           msip_m[31:1], presc_m[31:PRESC_W]};

    // Next-state for counters, registers, read port and interrupt
    always_comb begin
        mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d  = mtimecmp_q;
        msip_d      = msip_q;
        prescale_d  = prescale_q;
        presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
        hi_shadow_d = hi_shadow_q;
        rd_data_d   = 32'h0;
        hit_d       = rd;
        tirq_d      = mtime_q >= mtimecmp_q;

        if (wr) begin
            case (ofs)
                OFS_MTIME_LO: mtime_d = {mtime_q[63:32], mtime_lo_m};
                OFS_MTIME_HI: begin
                    mtime_d     = {mtime_hi_m, mtime_q[31:0]};
                    hi_shadow_d = shadow_m;
                end
                OFS_MTIMECMP_LO: mtimecmp_d[31:0]  = cmp_lo_m;
                OFS_MTIMECMP_HI: mtimecmp_d[63:32] = cmp_hi_m;
                OFS_MSIP:        msip_d = msip_m[0];
                OFS_PRESC: begin
                    prescale_d  = presc_m[PRESC_W-1:0];
                    presc_cnt_d = '0;
                end
                default: ;
            endcase
        end

        if (rd) begin
            case (ofs)
                OFS_MTIME_LO: begin
                    rd_data_d   = mtime_q[31:0];
                    hi_shadow_d = mtime_q[63:32];
                end
                OFS_MTIME_HI:    rd_data_d = hi_shadow_q;
                OFS_MTIMECMP_LO: rd_data_d = mtimecmp_q[31:0];
                OFS_MTIMECMP_HI: rd_data_d = mtimecmp_q[63:32];
                OFS_MSIP:        rd_data_d = {31'b0, msip_q};
                OFS_PRESC:       rd_data_d = presc_ext;
                default:         rd_data_d = 32'h0;
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            mtime_q     <= MTIME_RST;
            mtimecmp_q  <= MTIMECMP_RST;
            msip_q      <= 1'b0;
            prescale_q  <= '0;
            presc_cnt_q <= '0;
            hi_shadow_q <= 32'h0;
            rd_data_q   <= 32'h0;
            hit_q       <= 1'b0;
            tirq_q      <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            prescale_q  <= prescale_d;
            presc_cnt_q <= presc_cnt_d;
            hi_shadow_q <= hi_shadow_d;
            rd_data_q   <= rd_data_d;
            hit_q       <= hit_d;
            tirq_q      <= tirq_d;
        end
    end

    assign tmr_rd_data_out        = rd_data_q;
    assign tmr_hit_out            = hit_q;
    assign ms_riscv32_mp_rc_out   = mtime_q;
    assign ms_riscv32_mp_tirq_out = tirq_q;
    assign ms_riscv32_mp_sirq_out = msip_q;

endmodule

// File: doc/msrv32_timer_unit.md
Name: msrv32_timer_unit

Overview:
- Memory-mapped machine timer and software-interrupt peripheral on the core's data-memory port.
- Decodes the core's data-memory write/address bus and returns registered read data for the load path.
- Produces the 64-bit real-time count that feeds the core's rc input.
- Produces the timer and software interrupt requests that feed the core's tirq and sirq inputs.

Parameters:
- BASE_ADDR, 32'h0200_0000: base of the 64-byte register window. Bits [5:0] must be zero.
- PRESC_W, 8: width of the prescaler register and its counter.

Ports:
- ms_riscv32_mp_clk_in, input, 1: core clock.
- ms_riscv32_mp_rst_in, input, 1: synchronous active-high reset.
- ms_riscv32_mp_dmaddr_in, input, 32: data-memory address from the core's store unit.
- ms_riscv32_mp_dmdata_in, input, 32: write data from the core.
- ms_riscv32_mp_dmwr_req_in, input, 1: write request.
- ms_riscv32_mp_dmwr_mask_in, input, 4: byte-write mask; bit n enables byte n.
- tmr_rd_data_out, output, 32: registered read data, muxed onto the core's dmdata input.
- tmr_hit_out, output, 1: registered flag meaning the previous-cycle address hit the window. Used as the system read-mux select.
- ms_riscv32_mp_rc_out, output, 64: current mtime value; drives the core's rc input.
- ms_riscv32_mp_tirq_out, output, 1: timer interrupt request (registered).
- ms_riscv32_mp_sirq_out, output, 1: software interrupt request, equal to msip bit 0.

Behaviour:
- Reset values (clocked by ms_riscv32_mp_rst_in, synchronous):
  - mtime = 0
  - mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF
  - msip = 0
  - prescale = 0
  - presc_cnt = 0
  - hi_shadow = 0
  - tmr_rd_data_out = 0
  - tmr_hit_out = 0
  - tirq = 0
  - sirq = 0
- Reset asserted mid-operation wins over every write and every increment in that cycle.
- Window decode: hit = (addr[31:6] == BASE_ADDR[31:6]). Word offset = addr[5:2]; addr[1:0] is ignored.
- Register map (word offsets):
  - 0: mtime_lo, RW
  - 1: mtime_hi, RW
  - 2: mtimecmp_lo, RW
  - 3: mtimecmp_hi, RW
  - 4: msip, RW, bit 0 only; upper bits read 0
  - 5: prescale, RW, bits [PRESC_W-1:0]
  - 6 to 15: reserved; writes ignored, reads return 0.
- Prescaler:
  - Tick when presc_cnt == prescale. On a tick, presc_cnt <= 0; otherwise presc_cnt increments.
  - prescale = 0 gives a tick every cycle; prescale = N gives one tick every N+1 cycles.
  - A write to prescale also clears presc_cnt.
- mtime:
  - Increments by 1 on each tick, modulo 2^64 (all-ones wraps to 0 with no flag).
  - Any write to offset 0 or 1 suppresses that cycle's increment. Masked bytes take the write data; all other mtime bytes hold.
- Writes: take effect at the clock edge where dmwr_req_in=1 and hit=1. Byte mask applies to every register. A write with mask 4'b0000 has no effect, including no increment suppression.
- Reads:
  - Every cycle with hit=1 and dmwr_req_in=0 is a read.
  - On the next cycle, tmr_rd_data_out holds the selected register value as it stood before the edge, and tmr_hit_out=1.
  - On a non-hit cycle, or a hit write cycle, the next cycle has tmr_hit_out=0 and tmr_rd_data_out=0.
  - Read latency is exactly 1 cycle; there is no back-pressure.
- 64-bit coherent read:
  - A read of offset 0 returns mtime[31:0] and captures mtime[63:32] into hi_shadow at the same edge.
  - A read of offset 1 returns hi_shadow, not live mtime[63:32].
  - A write to offset 1 also updates hi_shadow with the written bytes.
- Timer interrupt: tirq <= (mtime >= mtimecmp), unsigned 64-bit compare using pre-edge register values. Response is therefore one cycle after the condition changes.
- Software interrupt: sirq is msip bit 0. It is set or cleared by a write to offset 4 and appears on the cycle after the write.
- Simultaneous events: a write to mtimecmp on the same edge where mtime crosses it. tirq computed at the following edge uses the new values, so there is no stale level beyond 1 cycle.

Decomposition:
- Shared package msrv32_timer_pkg:
  - word offset constants: OFS_MTIME_LO, OFS_MTIME_HI, OFS_MTIMECMP_LO, OFS_MTIMECMP_HI, OFS_MSIP, OFS_PRESC
  - reset constants: MTIMECMP_RST (all ones), MTIME_RST (0)
- One sub-module: msrv32_byte_mask_merge, combinational, (old[31:0], new[31:0], mask[3:0]) -> merged[31:0]. Reused for all RW registers.
- Prescaler, mtime counter, decode, read mux and interrupt logic stay in the top.

Test Plan:
- Reset then idle 10 cycles with prescale=0 -> ms_riscv32_mp_rc_out = 10, tirq=0, sirq=0, tmr_hit_out=0.
- Write prescale=3, then idle 12 cycles -> mtime advances by exactly 3, once every 4 cycles.
- Write mtime_lo=32'hFFFF_FFFF and mtime_hi=32'hFFFF_FFFF, then 1 tick -> mtime = 0 (wrap).
- Write mtime_hi=32'h0000_0001 with mask 4'b0001 -> only byte 0 is changed, and there is no increment that cycle.
- Write mtimecmp=20 with mtime=0 and prescale=0 -> tirq goes high 1 cycle after mtime reaches 20.
- Then write mtimecmp_hi=1 -> tirq falls 1 cycle later.
- Read offset 0 with mtime=32'h1_FFFF_FFFF, keep ticking, read offset 1 three cycles later -> data 32'hFFFF_FFFF, then 32'h0000_0001 (shadow value), each with tmr_hit_out=1.
- Write msip=1 -> sirq=1 next cycle; read offset 7 -> 0.
- Write to addr BASE_ADDR+0x40 -> no register changes, tmr_hit_out=0.
